// File: rtl/sh7034_ubc_match.sv
// sh7034_ubc_match: SH7034 UBC break-condition engine raising a held user-break request
//
// Ports:
//   CLK, RST_N         system clock, async active-low reset
//   CE_R, CE_F         rising/falling-phase clock enables
//   RES_N              sync chip reset, sampled on CE_R
//   BAR, BAMR, BBR     live UBC break address, address mask, bus-cycle condition
//   BUS_*              monitored internal bus cycle (accepted when BUS_REQ && !BUS_BUSY)
//   IRQ_ACK            INTC acknowledge, sampled on CE_R
//   IRQ                user-break request level
//   HIT                one-CLK pulse per detected match
module sh7034_ubc_match #(
   parameter int ADDR_W = 28
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              CE_R,
   input  logic              CE_F,
   input  logic              RES_N,
   input  logic [31:0]       BAR,
   input  logic [31:0]       BAMR,
   input  logic [15:0]       BBR,
   input  logic [ADDR_W-1:0] BUS_A,
   input  logic [3:0]        BUS_BA,
   input  logic              BUS_WE,
   input  logic              BUS_IF,
   input  logic              BUS_DMA,
   input  logic              BUS_REQ,
   input  logic              BUS_BUSY,
   input  logic              IRQ_ACK,
   output logic              IRQ,
   output logic              HIT
);
   logic              s1_v, s1_we, s1_if, s1_dma, pend;
   logic [ADDR_W-1:0] s1_a;
   logic [3:0]        s1_ba;
   logic              addr_ok, cd_ok, id_ok, rw_ok, sz_ok, match, accept;
   // CD/ID/RW each select one enable bit, so a 00 field can never qualify
   always_comb begin
      accept  = BUS_REQ & ~BUS_BUSY;
      addr_ok = ((32'(s1_a) ^ BAR) & ~BAMR) == 32'd0;
      cd_ok   = s1_dma ? BBR[7] : BBR[6];
      id_ok   = s1_if ? BBR[4] : BBR[5];
      rw_ok   = s1_we ? BBR[3] : BBR[2];
      sz_ok   = BBR[1:0] == 2'b00 ? 1'b1 :
                BBR[1:0] == 2'b01 ? $onehot(s1_ba) :
                BBR[1:0] == 2'b10 ? (s1_ba == 4'b1100 || s1_ba == 4'b0011) :
                                    s1_ba == 4'b1111;
      match   = CE_F & s1_v & addr_ok & cd_ok & id_ok & rw_ok & sz_ok;
   end
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         s1_v   <= 1'b0;
         s1_a   <= '0;
         s1_ba  <= '0;
         s1_we  <= 1'b0;
         s1_if  <= 1'b0;
         s1_dma <= 1'b0;
         pend   <= 1'b0;
         HIT    <= 1'b0;
      end else if (CE_R && !RES_N) begin
         s1_v   <= 1'b0;
         s1_a   <= '0;
         s1_ba  <= '0;
         s1_we  <= 1'b0;
         s1_if  <= 1'b0;
         s1_dma <= 1'b0;
         pend   <= 1'b0;
         HIT    <= 1'b0;
      end else begin
         HIT  <= match;
         // a new match wins over an acknowledge in the same CLK
         pend <= match ? 1'b1 : (CE_R && IRQ_ACK) ? 1'b0 : pend;
         if (CE_R) begin
            s1_v <= accept;
            if (accept) begin
               s1_a   <= BUS_A;
               s1_ba  <= BUS_BA;
               s1_we  <= BUS_WE;
               s1_if  <= BUS_IF;
               s1_dma <= BUS_DMA;
            end
         end
      end
   end
   assign IRQ = pend;
endmodule

// File: tb/tb_sh7034_ubc_match.sv
// tb_sh7034_ubc_match: table-driven, directed and randomized check of sh7034_ubc_match
module tb_sh7034_ubc_match;
   logic        clk = 0, rst_n = 0, ce_r = 0, ce_f = 0, res_n = 1;
   logic [31:0] bar = 0, bamr = 0;
   logic [15:0] bbr = 0;
   logic [27:0] bus_a = 0;
   logic [3:0]  bus_ba = 0;
   logic        bus_we = 0, bus_if = 0, bus_dma = 0, bus_req = 0, bus_busy = 0, ack = 0;
   logic        irq, hit;
   int          tests = 0, fails = 0;

   sh7034_ubc_match #(.ADDR_W(28)) dut (
      .CLK(clk), .RST_N(rst_n), .CE_R(ce_r), .CE_F(ce_f), .RES_N(res_n),
      .BAR(bar), .BAMR(bamr), .BBR(bbr), .BUS_A(bus_a), .BUS_BA(bus_ba),
      .BUS_WE(bus_we), .BUS_IF(bus_if), .BUS_DMA(bus_dma), .BUS_REQ(bus_req),
      .BUS_BUSY(bus_busy), .IRQ_ACK(ack), .IRQ(irq), .HIT(hit)
   );

   always #5 clk = ~clk;

   // reference: the captured cycle waiting for compare, and the pending request
   bit          m_v, m_p, m_h;
   logic [27:0] m_a;
   logic [3:0]  m_ba;
   bit          m_we, m_if, m_dma;

   function automatic bit spec_match(logic [31:0] a, logic [3:0] ba, bit we, bit i_f, bit dma);
      int  n  = $countones(ba);
      int  sz = int'(bbr[1:0]);
      bit  sz_ok = (sz == 0) || (sz == 1 && n == 1) ||
                   (sz == 2 && (ba == 4'hC || ba == 4'h3)) || (sz == 3 && ba == 4'hF);
      bit  cd = dma ? bbr[7] : bbr[6];
      bit  id = i_f ? bbr[4] : bbr[5];
      bit  rw = we ? bbr[3] : bbr[2];
      return (((a ^ bar) & ~bamr) == 32'd0) && cd && id && rw && sz_ok;
   endfunction

   task automatic check(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic tick();
      bit m = ce_f && m_v && spec_match({4'h0, m_a}, m_ba, m_we, m_if, m_dma);
      bit nv = m_v, np = m_p, nh = 0;
      logic [27:0] na = m_a;
      logic [3:0]  nba = m_ba;
      bit nwe = m_we, nif = m_if, ndma = m_dma;
      if (!rst_n || (ce_r && !res_n)) begin
         nv = 0; np = 0; nh = 0;
      end else begin
         nh = m;
         if (m) np = 1;
         else if (ce_r && ack) np = 0;
         if (ce_r) begin
            nv = bus_req && !bus_busy;
            if (nv) begin na = bus_a; nba = bus_ba; nwe = bus_we; nif = bus_if; ndma = bus_dma; end
         end
      end
      @(posedge clk);
      #1;
      m_v = nv; m_p = np; m_h = nh; m_a = na; m_ba = nba; m_we = nwe; m_if = nif; m_dma = ndma;
      check("model_irq", irq, m_p);
      check("model_hit", hit, m_h);
   endtask

   task automatic drv(input bit r, input bit f);
      ce_r = r; ce_f = f;
   endtask

   typedef struct {
      logic [15:0] bbr;
      logic [31:0] bamr;
      logic [27:0] a;
      logic [3:0]  ba;
      bit          we, i_f, dma, exp_hit;
      string       name;
   } vec_t;

   task automatic xact(input vec_t v);
      bbr = v.bbr; bamr = v.bamr;
      bus_a = v.a; bus_ba = v.ba; bus_we = v.we; bus_if = v.i_f; bus_dma = v.dma;
      bus_req = 1; bus_busy = 0; drv(1, 0); tick();
      bus_req = 0; drv(0, 1); tick();
      check({v.name, "_hit"}, hit, v.exp_hit);
      check({v.name, "_irq"}, irq, v.exp_hit);
      ack = 1; drv(1, 0); tick();
      check({v.name, "_ack"}, irq, 1'b0);
      ack = 0; drv(0, 1); tick();
   endtask

   initial begin
      vec_t vecs[12];
      int   hits;
      vecs[0]  = '{16'h0054, 32'h0, 28'h6001000, 4'hF, 0, 1, 0, 1, "fetch_hit"};
      vecs[1]  = '{16'h0054, 32'h0, 28'h6001004, 4'hF, 0, 1, 0, 0, "fetch_miss"};
      vecs[2]  = '{16'h0054, 32'hF, 28'h6001004, 4'hF, 0, 1, 0, 1, "masked_hit"};
      vecs[3]  = '{16'h0069, 32'h0, 28'h6001000, 4'h2, 1, 0, 0, 1, "wr_byte"};
      vecs[4]  = '{16'h0069, 32'h0, 28'h6001000, 4'h3, 1, 0, 0, 0, "wr_word_vs_byte"};
      vecs[5]  = '{16'h0069, 32'h0, 28'h6001000, 4'h2, 0, 0, 0, 0, "rd_vs_wr"};
      vecs[6]  = '{16'h0069, 32'h0, 28'h6001000, 4'h2, 1, 0, 1, 0, "dma_vs_cpu"};
      vecs[7]  = '{16'h006A, 32'h0, 28'h6001000, 4'hC, 1, 0, 0, 1, "word_hi"};
      vecs[8]  = '{16'h006A, 32'h0, 28'h6001000, 4'h6, 1, 0, 0, 0, "word_bad"};
      vecs[9]  = '{16'h006B, 32'h0, 28'h6001000, 4'h7, 1, 0, 0, 0, "long_bad"};
      vecs[10] = '{16'h006B, 32'h0, 28'h6001000, 4'hF, 1, 0, 0, 1, "long_ok"};
      vecs[11] = '{16'h0000, 32'h0, 28'h6001000, 4'hF, 0, 1, 0, 0, "bbr_off"};
      bar = 32'h0600_1000;

      #1;
      check("async_rst_irq", irq, 1'b0);
      check("async_rst_hit", hit, 1'b0);
      tick(); tick();
      rst_n = 1;
      tick();

      foreach (vecs[i]) xact(vecs[i]);

      // busy stalls: one capture, one HIT
      bbr = 16'h0054; bamr = 0; bus_a = 28'h6001000; bus_ba = 4'hF;
      bus_we = 0; bus_if = 1; bus_dma = 0; bus_req = 1; bus_busy = 1; hits = 0;
      for (int k = 0; k < 3; k++) begin
         drv(1, 0); tick(); hits += int'(hit);
         drv(0, 1); tick(); hits += int'(hit);
      end
      bus_busy = 0; drv(1, 0); tick(); hits += int'(hit);
      bus_req = 0; drv(0, 1); tick(); hits += int'(hit);
      drv(1, 0); tick(); hits += int'(hit);
      drv(0, 1); tick(); hits += int'(hit);
      tests++;
      if (hits != 1) begin fails++; $display("FAIL busy_hits: got %0d expected 1", hits); end
      check("busy_irq", irq, 1'b1);

      // ack in the same CLK as a matching compare: set wins
      bus_req = 1; drv(1, 0); tick();
      bus_req = 0; ack = 1; drv(1, 1); tick();
      check("ack_vs_set_irq", irq, 1'b1);
      check("ack_vs_set_hit", hit, 1'b1);
      drv(1, 0); tick();
      check("ack_alone", irq, 1'b0);
      ack = 0; drv(0, 1); tick();

      // RES_N clears a pending request
      bus_req = 1; drv(1, 0); tick();
      bus_req = 0; drv(0, 1); tick();
      check("pre_res_irq", irq, 1'b1);
      res_n = 0; drv(1, 0); tick();
      check("res_irq", irq, 1'b0);
      res_n = 1; drv(0, 1); tick();

      // BBR disable does not clear an existing request
      bus_req = 1; drv(1, 0); tick();
      bus_req = 0; drv(0, 1); tick();
      bbr = 16'h0000; drv(1, 0); tick();
      check("bbr_off_keeps_irq", irq, 1'b1);
      ack = 1; drv(1, 0); tick(); ack = 0;

      // randomized traffic against the reference
      for (int k = 0; k < 3000; k++) begin
         int ph = k % 2;
         int r  = $urandom_range(0, 99);
         drv(r < 10 ? 1'b1 : ph == 0, r < 10 ? 1'b1 : (r < 15 ? 1'b0 : ph == 1));
         res_n = $urandom_range(0, 99) >= 2;
         ack = $urandom_range(0, 99) < 20;
         if ($urandom_range(0, 49) == 0) begin
            bar  = {4'h0, 28'($urandom)};
            bamr = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 255));
            bbr  = 16'($urandom);
         end
         bus_req  = $urandom_range(0, 99) < 60;
         bus_busy = $urandom_range(0, 99) < 30;
         bus_a    = bar[27:0] ^ (28'($urandom) & bamr[27:0]) ^ ($urandom_range(0, 9) == 0 ? 28'h10 : 28'h0);
         bus_ba   = 4'($urandom);
         bus_we   = 1'($urandom);
         bus_if   = 1'($urandom);
         bus_dma  = 1'($urandom);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sh7034_ubc_match.md
Name: sh7034_ubc_match

Overview:
- Break-condition engine directly downstream of the SH7034 UBC register block.
- Takes the live BAR, BAMR and BBR register contents and monitors accepted internal-bus cycles.
- On a qualified address/attribute match, raises a pending user-break request on IRQ toward the INTC.
- Holds IRQ until the INTC acknowledges.

Parameters:
- ADDR_W, 28, width of the monitored bus address; zero-extended to 32 bits for compare.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  reset, asynchronous, active-low
- CE_R  in  1  rising-phase clock enable
- CE_F  in  1  falling-phase clock enable
- RES_N  in  1  synchronous chip reset (manual/power-on), sampled on CE_R
- BAR  in  32  break address {BARH,BARL}
- BAMR  in  32  address mask {BAMRH,BAMRL}; 1 = bit excluded from compare
- BBR  in  16  break bus cycle register; bits [7:6] CD, [5:4] ID, [3:2] RW, [1:0] SZ
- BUS_A  in  ADDR_W  monitored bus address
- BUS_BA  in  4  byte lanes active
- BUS_WE  in  1  1 = write cycle
- BUS_IF  in  1  1 = instruction fetch, 0 = data access
- BUS_DMA  in  1  1 = DMA/peripheral-master cycle, 0 = CPU cycle
- BUS_REQ  in  1  cycle request
- BUS_BUSY  in  1  cycle stalled; a cycle is accepted when BUS_REQ && !BUS_BUSY
- IRQ_ACK  in  1  INTC acknowledge of the user-break request
- IRQ  out  1  user-break request (level)
- HIT  out  1  one-CLK pulse on each detected match (debug/perf)

Behaviour:
- Reset (RST_N low, async): all stage registers cleared; IRQ=0, HIT=0.
- RES_N low on CE_R: same clear as RST_N; overrides any simultaneous set.
- Stage 1, on CE_R with an accepted cycle:
  - Capture A = {zero-ext BUS_A}, BA, WE, IF, DMA.
  - Set S1_V=1.
  - On any CE_R without an accepted cycle, S1_V=0.
- Compare, on CE_F when S1_V=1, using live BAR/BAMR/BBR:
  - addr_ok = ((A ^ BAR) & ~BAMR) == 0.
  - cd_ok = DMA ? CD[1] : CD[0].
  - id_ok = IF ? ID[0] : ID[1].
  - rw_ok = WE ? RW[1] : RW[0].
  - sz_ok: SZ=00 → 1. SZ=01 → BA has exactly one bit set. SZ=10 → BA=1100 or 0011. SZ=11 → BA=1111. Any other BA pattern fails for SZ≠00.
  - match = addr_ok & cd_ok & id_ok & rw_ok & sz_ok.
  - Any of CD, ID or RW = 00 disables breaks entirely.
- On match at CE_F: PEND←1 and HIT pulses high for that CLK.
- Latency: IRQ rises at the CE_F immediately following the CE_R that captured the cycle.
- IRQ = PEND.
- IRQ_ACK sampled on CE_R clears PEND.
- Simultaneous events:
  - A match at a CE_F in the same CLK as an acknowledged clear leaves PEND=1; set has priority over ack.
  - Further matches while PEND=1 only pulse HIT; no queueing or counting.
- Register changes take effect at the next compare. A BBR write that disables breaks does not clear an existing PEND.
- BUS_BUSY held: the cycle is captured once, on the CE_R where BUSY is low. No duplicate HIT.
- Back-to-back accepted cycles on consecutive CE_R are each compared once.

Test Plan:
- BAR=0x0600_1000, BAMR=0, BBR=0x0054 (CPU, fetch, read, any size); CPU fetch read at 0x6001000, BA=1111 → HIT pulse, IRQ=1 at next CE_F. IRQ_ACK → IRQ=0.
- Same setup, fetch at 0x6001004 → no HIT. Set BAMR=0x0000_000F and repeat → HIT.
- BBR=0x0069 (CPU, data, write, byte):
  - Write BA=0010 → match.
  - Write BA=0011 → no match.
  - Read BA=0010 → no match.
  - DMA write BA=0010 → no match.
- BUS_REQ=1 with BUS_BUSY high for 3 CE_R, then low → exactly one HIT, one IRQ assertion.
- IRQ_ACK asserted in the same CLK as a new matching compare → IRQ remains 1. A second ACK with no match → IRQ=0.
- IRQ=1, then RES_N=0 for one CE_R → IRQ=0. With BBR=0x0000, matching traffic → no HIT.
